// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
//
// Port 0 is the processor, port 1 the loader/debug requester. One access is
// granted per cycle, combinationally from the requests, the arbitration state
// and the priority pointer. A granted port may lock ownership across
// consecutive accesses. Reads return one cycle after the grant.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_n, we_n, lock_n     per-requester request, write enable, lock
//   addr_n[11:0]            per-requester word address
//   wdata_n[31:0]           per-requester write data
//   gnt_n                   access accepted this cycle
//   rvalid_n, rdata_n[31:0] read data valid pulse and read data
//   address_dmem[11:0]      memory address
//   data[31:0], wren        memory write data and write enable
//   q_dmem[31:0]            memory read data (one-cycle latency)
//
// Configuration:
//   DMEM_ARB_FIXED_PRIO_EN  defined: port 0 always wins contention in ARB.
//                           undefined: round-robin on contention.

module dmem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_0,
    input  logic        we_0,
    input  logic [11:0] addr_0,
    input  logic [31:0] wdata_0,
    input  logic        lock_0,
    output logic        gnt_0,
    output logic        rvalid_0,
    output logic [31:0] rdata_0,
    input  logic        req_1,
    input  logic        we_1,
    input  logic [11:0] addr_1,
    input  logic [31:0] wdata_1,
    input  logic        lock_1,
    output logic        gnt_1,
    output logic        rvalid_1,
    output logic [31:0] rdata_1,
    output logic [11:0] address_dmem,
    output logic [31:0] data,
    output logic        wren,
    input  logic [31:0] q_dmem
);

    typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_gnt_0;
    logic        w_gnt_1;
    logic [11:0] r_addr;
    logic [31:0] r_data;
    logic        r_rd_pend_0;
    logic        r_rd_pend_1;
    logic [31:0] r_rdata_0;
    logic [31:0] r_rdata_1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Id of the most recently granted port; the other port wins contention.
    logic        r_ptr;
`endif

    always_comb begin
        w_gnt_0      = 1'b0;
        w_gnt_1      = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ARB: begin
                if (req_0 && req_1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    w_gnt_0 = 1'b1;
`else
                    w_gnt_0 = r_ptr;
                    w_gnt_1 = ~r_ptr;
`endif
                end else begin
                    w_gnt_0 = req_0;
                    w_gnt_1 = req_1;
                end
                if (w_gnt_0 && lock_0) begin
                    w_state_next = LOCK0;
                end else if (w_gnt_1 && lock_1) begin
                    w_state_next = LOCK1;
                end
            end
            LOCK0: begin
                // Final access (lock dropped) is still granted.
                w_gnt_0 = req_0;
                if (!req_0 || !lock_0) begin
                    w_state_next = ARB;
                end
            end
            LOCK1: begin
                w_gnt_1 = req_1;
                if (!req_1 || !lock_1) begin
                    w_state_next = ARB;
                end
            end
            default: w_state_next = ARB;
        endcase
        if (reset) begin
            w_gnt_0 = 1'b0;
            w_gnt_1 = 1'b0;
        end
    end

    always_comb begin
        address_dmem = r_addr;
        data         = r_data;
        wren         = 1'b0;
        if (w_gnt_0) begin
            address_dmem = addr_0;
            data         = wdata_0;
            wren         = we_0;
        end else if (w_gnt_1) begin
            address_dmem = addr_1;
            data         = wdata_1;
            wren         = we_1;
        end
    end

    assign gnt_0    = w_gnt_0;
    assign gnt_1    = w_gnt_1;
    assign rvalid_0 = r_rd_pend_0;
    assign rvalid_1 = r_rd_pend_1;
    // Memory data passes straight through in the return cycle, then is held.
    assign rdata_0  = r_rd_pend_0 ? q_dmem : r_rdata_0;
    assign rdata_1  = r_rd_pend_1 ? q_dmem : r_rdata_1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ARB;
            r_addr      <= 12'h000;
            r_data      <= 32'h0000_0000;
            r_rd_pend_0 <= 1'b0;
            r_rd_pend_1 <= 1'b0;
            r_rdata_0   <= 32'h0000_0000;
            r_rdata_1   <= 32'h0000_0000;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            r_ptr       <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_next;
            r_rd_pend_0 <= w_gnt_0 & ~we_0;
            r_rd_pend_1 <= w_gnt_1 & ~we_1;
            if (w_gnt_0 || w_gnt_1) begin
                r_addr <= address_dmem;
                r_data <= data;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                r_ptr  <= w_gnt_1;
`endif
            end
            if (r_rd_pend_0) begin
                r_rdata_0 <= q_dmem;
            end
            if (r_rd_pend_1) begin
                r_rdata_1 <= q_dmem;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.

module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_0 = 1'b0, we_0 = 1'b0, lock_0 = 1'b0;
    logic        req_1 = 1'b0, we_1 = 1'b0, lock_1 = 1'b0;
    logic [11:0] addr_0 = '0, addr_1 = '0;
    logic [31:0] wdata_0 = '0, wdata_1 = '0;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1, wren;
    logic [31:0] rdata_0, rdata_1, data;
    logic [11:0] address_dmem;
    logic [31:0] q_dmem;

    int errors = 0;
    int checks = 0;

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .lock_0(lock_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .lock_1(lock_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    always #5 clock = ~clock;

    // Synchronous memory: read-first, one-cycle read latency.
    logic [31:0] mem     [4096];
    logic [31:0] ref_mem [4096];

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        mem[12'h010]     = 32'hDEAD_BEEF;
        ref_mem[12'h010] = 32'hDEAD_BEEF;
    end

    always @(posedge clock) begin
        if (wren) mem[address_dmem] <= data;
        q_dmem <= mem[address_dmem];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_owner;  // -1: arbitrating, else id of locking port
    int          m_last;   // id of most recently granted port
    logic [11:0] m_addr;
    logic [31:0] m_data;
    bit          m_pend0, m_pend1;
    logic [31:0] m_pv0, m_pv1, m_hold0, m_hold1;

    function automatic int winner();
        if (reset) return -1;
        if (m_owner == 0) return req_0 ? 0 : -1;
        if (m_owner == 1) return req_1 ? 1 : -1;
        if (req_0 && req_1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (m_last == 0) ? 1 : 0;
`endif
        end
        if (req_0) return 0;
        if (req_1) return 1;
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_last  = 1;
        m_addr  = '0;
        m_data  = '0;
        m_pend0 = 0;
        m_pend1 = 0;
        m_hold0 = '0;
        m_hold1 = '0;
    endtask

    initial begin : model
        int          w;
        logic [11:0] ea;
        logic [31:0] ed;
        bit          ewr;
        @(posedge clock);
        m_reset();
        forever begin
            @(negedge clock);
            w   = winner();
            ewr = (w == 0 && we_0) || (w == 1 && we_1);
            chk("mdl_gnt_0", {31'b0, gnt_0}, {31'b0, w == 0});
            chk("mdl_gnt_1", {31'b0, gnt_1}, {31'b0, w == 1});
            chk("mdl_wren", {31'b0, wren}, {31'b0, ewr});
            if (!reset) begin
                ea = (w == 0) ? addr_0 : (w == 1) ? addr_1 : m_addr;
                ed = (w == 0) ? wdata_0 : (w == 1) ? wdata_1 : m_data;
                chk("mdl_address", {20'b0, address_dmem}, {20'b0, ea});
                chk("mdl_data", data, ed);
            end
            chk("mdl_rvalid_0", {31'b0, rvalid_0}, {31'b0, m_pend0});
            chk("mdl_rvalid_1", {31'b0, rvalid_1}, {31'b0, m_pend1});
            chk("mdl_rdata_0", rdata_0, m_pend0 ? m_pv0 : m_hold0);
            chk("mdl_rdata_1", rdata_1, m_pend1 ? m_pv1 : m_hold1);
            @(posedge clock);
            if (reset) begin
                m_reset();
            end else begin
                if (m_pend0) m_hold0 = m_pv0;
                if (m_pend1) m_hold1 = m_pv1;
                m_pend0 = (w == 0) && !we_0;
                m_pend1 = (w == 1) && !we_1;
                if (m_pend0) m_pv0 = ref_mem[addr_0];
                if (m_pend1) m_pv1 = ref_mem[addr_1];
                if (w >= 0) begin
                    m_addr = ea;
                    m_data = ed;
                    m_last = w;
                    if (ewr) ref_mem[ea] = ed;
                end
                if (m_owner < 0) begin
                    if (w == 0 && lock_0) m_owner = 0;
                    else if (w == 1 && lock_1) m_owner = 1;
                end else if (m_owner == 0) begin
                    if (!req_0 || !lock_0) m_owner = -1;
                end else begin
                    if (!req_1 || !lock_1) m_owner = -1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_0 = 0; we_0 = 0; lock_0 = 0; addr_0 = '0; wdata_0 = '0;
        req_1 = 0; we_1 = 0; lock_1 = 0; addr_1 = '0; wdata_1 = '0;
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [11:0] a0,
                         input logic [31:0] d0, input bit l0,
                         input bit r1, input bit w1, input logic [11:0] a1,
                         input logic [31:0] d1, input bit l1);
        req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0; lock_0 = l0;
        req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1; lock_1 = l1;
    endtask

    // Leaves reset high for one cycle; the caller's next step releases it.
    task automatic do_reset();
        step();
        reset = 1;
        idle();
    endtask

    bit exp_g0 [4];

    initial begin : stim
        idle();
        step();
        @(negedge clock);
        chk("rst_gnt_0", {31'b0, gnt_0}, 32'd0);
        chk("rst_gnt_1", {31'b0, gnt_1}, 32'd0);
        chk("rst_wren", {31'b0, wren}, 32'd0);
        chk("rst_rvalid_0", {31'b0, rvalid_0}, 32'd0);
        chk("rst_address", {20'b0, address_dmem}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_rdata_0", rdata_0, 32'd0);

        // Single read.
        step(); reset = 0;
        drive(1, 0, 12'h010, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rd_gnt_0", {31'b0, gnt_0}, 32'd1);
        chk("rd_address", {20'b0, address_dmem}, 32'h010);
        step(); idle();
        @(negedge clock);
        chk("rd_rvalid_0", {31'b0, rvalid_0}, 32'd1);
        chk("rd_rdata_0", rdata_0, 32'hDEAD_BEEF);
        chk("rd_rvalid_1", {31'b0, rvalid_1}, 32'd0);

        // Continuous contention.
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_g0 = '{1, 1, 1, 1};
`else
        exp_g0 = '{1, 0, 1, 0};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(); reset = 0;
            drive(1, 0, 12'h100, 0, 0, 1, 0, 12'h101, 0, 0);
            @(negedge clock);
            chk("rr_gnt_0", {31'b0, gnt_0}, {31'b0, exp_g0[i]});
            chk("rr_gnt_1", {31'b0, gnt_1}, {31'b0, !exp_g0[i]});
        end

        // Read-after-write across ports.
        step();
        drive(0, 0, 0, 0, 0, 1, 1, 12'h055, 32'h1234_5678, 0);
        @(negedge clock);
        chk("raw_wren", {31'b0, wren}, 32'd1);
        chk("raw_waddr", {20'b0, address_dmem}, 32'h055);
        chk("raw_wdata", data, 32'h1234_5678);
        step();
        drive(1, 0, 12'h055, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("raw_gnt_0", {31'b0, gnt_0}, 32'd1);
        step(); idle();
        @(negedge clock);
        chk("raw_rdata_0", rdata_0, 32'h1234_5678);

        // Port 1 locks for three accesses while port 0 waits.
        do_reset();
        step(); reset = 0;
        drive(1, 0, 12'h020, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("lk_pre_gnt_0", {31'b0, gnt_0}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
`ifdef DMEM_ARB_FIXED_PRIO_EN
            drive(k != 0, 0, 12'h021, 0, 0, 1, 1, 12'h200 + 12'(k), 32'(k), k < 2);
`else
            drive(1, 0, 12'h021, 0, 0, 1, 1, 12'h200 + 12'(k), 32'(k), k < 2);
`endif
            @(negedge clock);
            chk("lk_gnt_0", {31'b0, gnt_0}, 32'd0);
            chk("lk_gnt_1", {31'b0, gnt_1}, 32'd1);
        end
        step();
        drive(1, 0, 12'h021, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("lk_rel_gnt_0", {31'b0, gnt_0}, 32'd1);

        // Port 0 pulse while port 1 holds the lock.
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 12'h300, 0, 1);
        @(negedge clock);
        chk("pl_gnt_1", {31'b0, gnt_1}, 32'd1);
        step();
        drive(1, 1, 12'h301, 32'hFFFF_FFFF, 0, 1, 0, 12'h300, 0, 1);
        @(negedge clock);
        chk("pl_gnt_0", {31'b0, gnt_0}, 32'd0);
        chk("pl_wren", {31'b0, wren}, 32'd0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 12'h300, 0, 0);
        @(negedge clock);
        chk("pl_rvalid_0", {31'b0, rvalid_0}, 32'd0);

        // Reset in the cycle a read would be granted.
        step(); reset = 1;
        drive(1, 0, 12'h010, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rr_rst_gnt_0", {31'b0, gnt_0}, 32'd0);
        step(); reset = 0; idle();
        @(negedge clock);
        chk("rr_rst_rvalid_0", {31'b0, rvalid_0}, 32'd0);
        chk("rr_rst_rdata_0", rdata_0, 32'd0);
        chk("rr_rst_rdata_1", rdata_1, 32'd0);
        chk("rr_rst_address", {20'b0, address_dmem}, 32'd0);
        chk("rr_rst_data", data, 32'd0);

        // Randomized traffic, small address window for frequent collisions.
        for (int n = 0; n < 3000; n++) begin
            step();
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  12'h050 + 12'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  12'h050 + 12'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
        end
        step(); reset = 0; idle();
        step();
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
